// File: rtl/five_stage_subtractor_if.sv
// Ready/valid bus for five_stage_subtractor.
// Upstream side: valid_i, ready_o, sum_i, data_2.
// Downstream side: valid_o, ready_i, data_out, err_o.
// The subtractor uses the slave modport. A test harness acting as both
// neighbours uses the master modport.
interface five_stage_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH:0]   sum_i;
  logic [WIDTH-1:0] data_2;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_out;
  logic             err_o;

  modport master (
    output valid_i, sum_i, data_2, ready_i,
    input  ready_o, valid_o, data_out, err_o
  );

  modport slave (
    input  valid_i, sum_i, data_2, ready_i,
    output ready_o, valid_o, data_out, err_o
  );
endinterface

// File: rtl/five_stage_subtractor.sv
// five_stage_subtractor: recovers data_1 = sum_i - data_2 through a 5-stage
// pipeline with ready/valid backpressure.
//   S1     : registers the operands; the borrow starts at 0.
//   S2..S5 : each stage subtracts one CHUNK-bit slice with the ripple borrow.
//   S5     : also resolves the top bit (sum[WIDTH] - borrow). A nonzero
//            result means the answer is outside [0, 2^WIDTH-1].
// The whole pipe advances together when adv = !valid_o || ready_i. Bubbles
// move forward like data and are not collapsed.
// Optional feature, selected by the macro FIVE_STAGE_SUB_ERR_CNT_EN:
//   adds port err_cnt, a saturating count of accepted beats that had err_o=1.
module five_stage_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  five_stage_subtractor_if.slave      bus
`ifdef FIVE_STAGE_SUB_ERR_CNT_EN
  ,
  output logic [15:0]                 err_cnt
`endif
);

  // Number of chunk stages (S2..S5). Index k below refers to the register
  // that feeds chunk k: index 0 is S1, and index 3 is S4.
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             s_valid  [NCHUNK];
  logic [WIDTH:0]   s_sum    [NCHUNK];
  logic [WIDTH-1:0] s_d2     [NCHUNK];
  logic [WIDTH-1:0] s_diff   [NCHUNK];
  logic             s_borrow [NCHUNK];

  logic [CHUNK:0]   sub_chunk  [NCHUNK];
  logic [WIDTH-1:0] nxt_diff   [NCHUNK];
  logic             nxt_borrow [NCHUNK];

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  logic             adv;
  logic signed [1:0] top;
  logic             top_err;

  assign adv         = !out_valid || bus.ready_i;
  assign bus.ready_o = adv;
  assign bus.valid_o = out_valid;
  assign bus.data_out = out_data;
  assign bus.err_o    = out_err;

  // Per-stage chunk subtraction: the slice for chunk k, with the borrow carried in from the previous chunk.
  always_comb begin
    for (int k = 0; k < NCHUNK; k++) begin
      // NOTE: every combinational output is given a full value on each pass
      // before any partial update, so no path can infer a latch.
      nxt_diff[k]  = s_diff[k];
      sub_chunk[k] = {1'b0, s_sum[k][CHUNK*k +: CHUNK]}
                   - {1'b0, s_d2[k][CHUNK*k +: CHUNK]}
                   - {{CHUNK{1'b0}}, s_borrow[k]};
      nxt_diff[k][CHUNK*k +: CHUNK] = sub_chunk[k][CHUNK-1:0];
      // A negative slice wraps modulo 2^(CHUNK+1), which sets the top bit.
      nxt_borrow[k] = sub_chunk[k][CHUNK];
    end
  end

  // Top-bit resolution for the final stage: any result other than 0 is out of range.
  assign top     = $signed({1'b0, s_sum[NCHUNK-1][WIDTH]})
                 - $signed({1'b0, nxt_borrow[NCHUNK-1]});
  assign top_err = (top != 2'sd0);

  // Pipeline registers S1..S4 and the S5 output register, all gated by adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage data registers are reset as well as the valids, so
      // the outputs never carry X once reset has been applied.
      for (int k = 0; k < NCHUNK; k++) begin
        s_valid[k]  <= 1'b0;
        s_sum[k]    <= '0;
        s_d2[k]     <= '0;
        s_diff[k]   <= '0;
        s_borrow[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage take its
      // predecessor's old value on the same edge; blocking would collapse
      // the pipe.
      s_valid[0]  <= bus.valid_i && adv;
      s_sum[0]    <= bus.sum_i;
      s_d2[0]     <= bus.data_2;
      s_diff[0]   <= '0;
      s_borrow[0] <= 1'b0;
      for (int k = 1; k < NCHUNK; k++) begin
        s_valid[k]  <= s_valid[k-1];
        s_sum[k]    <= s_sum[k-1];
        s_d2[k]     <= s_d2[k-1];
        s_diff[k]   <= nxt_diff[k-1];
        s_borrow[k] <= nxt_borrow[k-1];
      end
      out_valid <= s_valid[NCHUNK-1];
      out_err   <= top_err;
      out_data  <= top_err ? '0 : nxt_diff[NCHUNK-1];
    end
  end

`ifdef FIVE_STAGE_SUB_ERR_CNT_EN
  // Saturating count of error beats that the downstream side accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && bus.ready_i && out_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
